led_pulse_bank: RTL and testbench

//   Multi-channel LED pulse/blink generator; parametrised successor of the single-channel one-shot pulser.

---
 rtl/led_pulse_pkg.sv | 17 +
 rtl/led_pulse_chan.sv | 92 +++++++++
 rtl/led_pulse_bank.sv | 38 +++
 tb/tb_led_pulse_bank.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/led_pulse_pkg.sv
// led_pulse_pkg: shared mode/state types for the LED pulse bank
package led_pulse_pkg;

    typedef enum logic [1:0] {
        MODE_RETRIG  = 2'd0,
        MODE_HOLD    = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_RETRIG3 = 2'd3
    } led_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } led_state_e;

endpackage

// File: rtl/led_pulse_chan.sv
// led_pulse_chan: one LED channel, one-shot or blink-burst FSM with on/off counters
module led_pulse_chan
    import led_pulse_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic             stop,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_on_cycles,
    input  logic [CNT_W-1:0] cfg_off_cycles,
    input  logic [REP_W-1:0] cfg_repeats,
    output logic             led,
    output logic             busy,
    output logic             done
);

    led_state_e       state, state_n;
    led_mode_e        mode_q, mode_n;
    logic [CNT_W-1:0] cnt, cnt_n, on_q, on_n, off_q, off_n;
    logic [REP_W-1:0] rep, rep_n;
    logic             done_n, accept;

    // next state: stop beats trigger, trigger beats expiry, HOLD blocks retrigger while busy
    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        cnt_n   = cnt;
        on_n    = on_q;
        off_n   = off_q;
        rep_n   = rep;
        done_n  = 1'b0;
        accept  = trigger && !stop && cfg_on_cycles != '0 && !(state != IDLE && mode_q == MODE_HOLD);
        if (stop) begin
            state_n = IDLE;
            cnt_n   = '0;
            rep_n   = '0;
        end else if (accept) begin
            state_n = ON;
            mode_n  = led_mode_e'(cfg_mode);
            cnt_n   = cfg_on_cycles;
            on_n    = cfg_on_cycles;
            off_n   = cfg_off_cycles;
            rep_n   = cfg_repeats == '0 ? REP_W'(1) : cfg_repeats;
        end else if (state == ON) begin
            if (cnt > CNT_W'(1)) begin
                cnt_n = cnt - CNT_W'(1);
            end else if (rep > REP_W'(1) && mode_q == MODE_BLINK) begin
                state_n = OFF;
                cnt_n   = off_q == '0 ? CNT_W'(1) : off_q;
                rep_n   = rep - REP_W'(1);
            end else begin
                state_n = IDLE;
                cnt_n   = '0;
                rep_n   = '0;
                done_n  = 1'b1;
            end
        end else if (state == OFF) begin
            state_n = cnt > CNT_W'(1) ? OFF : ON;
            cnt_n   = cnt > CNT_W'(1) ? cnt - CNT_W'(1) : on_q;
        end
    end

    // state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= MODE_RETRIG;
            cnt    <= '0;
            on_q   <= '0;
            off_q  <= '0;
            rep    <= '0;
            led    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            mode_q <= mode_n;
            cnt    <= cnt_n;
            on_q   <= on_n;
            off_q  <= off_n;
            rep    <= rep_n;
            led    <= state_n == ON;
            busy   <= state_n != IDLE;
            done   <= done_n;
        end
    end

endmodule

// File: rtl/led_pulse_bank.sv
// led_pulse_bank: CHANNELS independent LED pulse/blink channels sharing one config bus
module led_pulse_bank
    import led_pulse_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 32,
    parameter int REP_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] trigger,
    input  logic [CHANNELS-1:0] stop,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_on_cycles,
    input  logic [CNT_W-1:0]    cfg_off_cycles,
    input  logic [REP_W-1:0]    cfg_repeats,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        led_pulse_chan #(.CNT_W(CNT_W), .REP_W(REP_W)) u_chan (
            .clk            (clk),
            .rst            (rst),
            .trigger        (trigger[i]),
            .stop           (stop[i]),
            .cfg_mode       (cfg_mode),
            .cfg_on_cycles  (cfg_on_cycles),
            .cfg_off_cycles (cfg_off_cycles),
            .cfg_repeats    (cfg_repeats),
            .led            (led[i]),
            .busy           (busy[i]),
            .done           (done[i])
        );
    end

endmodule

// File: tb/tb_led_pulse_bank.sv
// tb_led_pulse_bank: directed scoreboard bench for led_pulse_bank
module tb_led_pulse_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  trigger, stop, led, busy, done;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_on_cycles, cfg_off_cycles;
    logic [7:0]  cfg_repeats;

    logic [11:0] sb[$];
    logic [11:0] got, want;
    int          checks = 0;
    int          errors = 0;
    string       tag;

    led_pulse_bank #(.CHANNELS(4), .CNT_W(32), .REP_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .trigger        (trigger),
        .stop           (stop),
        .cfg_mode       (cfg_mode),
        .cfg_on_cycles  (cfg_on_cycles),
        .cfg_off_cycles (cfg_off_cycles),
        .cfg_repeats    (cfg_repeats),
        .led            (led),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic exp(input int n, input logic [3:0] l, input logic [3:0] b, input logic [3:0] d);
        for (int i = 0; i < n; i++) sb.push_back({l, b, d});
    endtask

    task automatic setcfg(input logic [1:0] m, input int on, input int off, input int r);
        cfg_mode       = m;
        cfg_on_cycles  = on;
        cfg_off_cycles = off;
        cfg_repeats    = 8'(r);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s: scoreboard empty, observed %b", tag, {led, busy, done});
            end else begin
                want = sb.pop_front();
                got  = {led, busy, done};
                assert (got === want) else begin
                    errors++;
                    $error("FAIL %s step %0d: observed led/busy/done %b_%b_%b expected %b_%b_%b",
                           tag, i, got[11:8], got[7:4], got[3:0], want[11:8], want[7:4], want[3:0]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; trigger = '0; stop = '0;
        setcfg(0, 0, 0, 0);
        tag = "reset";
        exp(2, 0, 0, 0);
        run(2);
        rst = 1'b0;

        tag = "oneshot_on5";
        setcfg(0, 5, 0, 0); trigger = 4'h1;
        exp(5, 4'h1, 4'h1, 0); exp(1, 0, 0, 4'h1); exp(1, 0, 0, 0);
        run(1); trigger = 0; run(6);

        tag = "blink_3_2_3";
        setcfg(2, 3, 2, 3); trigger = 4'h2;
        exp(3, 4'h2, 4'h2, 0); exp(2, 0, 4'h2, 0);
        exp(3, 4'h2, 4'h2, 0); exp(2, 0, 4'h2, 0);
        exp(3, 4'h2, 4'h2, 0); exp(1, 0, 0, 4'h2); exp(1, 0, 0, 0);
        run(1); trigger = 0; run(14);

        tag = "retrig_on10";
        setcfg(0, 10, 0, 0); trigger = 4'h1;
        exp(13, 4'h1, 4'h1, 0); exp(1, 0, 0, 4'h1); exp(1, 0, 0, 0);
        run(1); trigger = 0; run(2); trigger = 4'h1; run(1); trigger = 0; run(11);

        tag = "mode3_trig_at_expiry";
        setcfg(3, 2, 0, 0); trigger = 4'h1;
        exp(4, 4'h1, 4'h1, 0); exp(1, 0, 0, 4'h1); exp(1, 0, 0, 0);
        run(1); trigger = 0; run(1); trigger = 4'h1; run(1); trigger = 0; run(3);

        tag = "hold_on10";
        setcfg(1, 10, 0, 0); trigger = 4'h8;
        exp(10, 4'h8, 4'h8, 0); exp(1, 0, 0, 4'h8); exp(1, 0, 0, 0);
        run(1); trigger = 0; run(3);
        setcfg(1, 4, 0, 0); trigger = 4'h8; run(1);
        trigger = 0; run(5);
        trigger = 4'h8; run(1);
        trigger = 0; run(1);

        tag = "stop_3rd_on";
        setcfg(0, 10, 0, 0); trigger = 4'h4;
        exp(3, 4'h4, 4'h4, 0); exp(3, 0, 0, 0);
        run(1); trigger = 0; run(2); stop = 4'h4; run(1); stop = 0; run(2);

        tag = "stop_and_trigger";
        trigger = 4'h4; stop = 4'h4;
        exp(2, 0, 0, 0);
        run(1); trigger = 0; stop = 0; run(1);

        tag = "on0_ignored";
        setcfg(0, 4, 0, 0); trigger = 4'h1;
        exp(4, 4'h1, 4'h1, 0); exp(1, 0, 0, 4'h1); exp(1, 0, 0, 0);
        run(1); setcfg(0, 0, 0, 0); trigger = 4'h3; run(1); trigger = 0; run(4);

        tag = "blink_rep0";
        setcfg(2, 2, 5, 0); trigger = 4'h2;
        exp(2, 4'h2, 4'h2, 0); exp(1, 0, 0, 4'h2); exp(1, 0, 0, 0);
        run(1); trigger = 0; run(3);

        tag = "multi_chan_reset";
        setcfg(2, 2, 1, 3); trigger = 4'h4;
        exp(1, 4'h4, 4'h4, 0); exp(1, 4'h5, 4'h5, 0); exp(1, 4'h1, 4'h5, 0);
        exp(1, 4'h5, 4'h5, 0); exp(2, 0, 0, 0);
        run(1); setcfg(0, 4, 0, 0); trigger = 4'h1; run(1);
        trigger = 0; run(2); rst = 1'b1; run(1); rst = 1'b0; run(1);

        tag = "scoreboard_drained";
        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL %s: observed %0d leftover entries, expected 0", tag, sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
